// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial subtractor D = A - B - Bin with valid/ready handshakes
//
// Purpose:
//   Computes D = A + ~B + ~Bin one 4-bit nibble per clock through a single
//   carry-lookahead slice. The carry is held in a register between nibbles.
//   Sequence: IDLE (accept operands) -> RUN (NIB cycles) -> DONE (hold result
//   until consumed) -> IDLE.
//
// Configuration macro:
//   NSS_SAT_EN - when defined, D saturates to the signed limit on overflow (V=1).
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      A, B, Bin valid
//   in_ready   out  1      unit can accept operands (IDLE)
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow in
//   out_valid  out  1      D and flags valid
//   out_ready  in   1      consumer accepts result
//   D          out  WIDTH  difference, low WIDTH bits
//   Bout       out  1      borrow out (1 iff A < B + Bin unsigned)
//   V          out  1      signed overflow
//   Z          out  1      1 iff unsaturated difference is zero

module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_nz;
  logic             r_bout;
  logic             r_v;
  logic             r_z;
  logic             r_out_valid;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_bn_nib;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_s;
  logic             w_last;
  logic             w_v;
  logic [WIDTH-1:0] w_d_next;
  logic [WIDTH-1:0] w_d_final;

  // Operands are shifted right one nibble per RUN cycle, so the slice always
  // works on bits [3:0]; on the last nibble bit 3 is the original sign bit.
  assign w_a_nib  = r_a[3:0];
  assign w_bn_nib = ~r_b[3:0];
  assign w_g      = w_a_nib & w_bn_nib;
  assign w_p      = w_a_nib ^ w_bn_nib;

  // Lookahead carries: each carry is a flat sum of products, no ripple chain.
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_p ^ w_c[3:0];

  assign w_last = (r_cnt == LAST_NIB);
  assign w_v    = (r_a[3] ^ r_b[3]) & (w_s[3] ^ r_a[3]);

  // Result nibbles enter at the top and shift down; after NIB cycles the
  // first nibble computed sits in D[3:0].
  assign w_d_next = {w_s, r_d[WIDTH-1:4]};

`ifdef NSS_SAT_EN
  assign w_d_final = !w_v    ? w_d_next :
                     r_a[3]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                               {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_d_final = w_d_next;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign Bout      = r_bout;
  assign V         = r_v;
  assign Z         = r_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_nz        <= 1'b0;
      r_bout      <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= ~Bin;
            r_cnt   <= '0;
            r_nz    <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= {4'b0000, r_a[WIDTH-1:4]};
          r_b     <= {4'b0000, r_b[WIDTH-1:4]};
          r_carry <= w_c[4];
          // Zero detect accumulates over raw nibbles, so Z ignores saturation.
          r_nz    <= r_nz | (|w_s);
          if (w_last) begin
            r_d         <= w_d_final;
            r_cnt       <= '0;
            r_bout      <= ~w_c[4];
            r_v         <= w_v;
            r_z         <= ~(r_nz | (|w_s));
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_d   <= w_d_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
